apu_frame_counter: RTL and testbench

- APU frame sequencer. Generates the `apu_cycle`, `qtrframe` and `halfframe` enable strobes consumed by the pulse, triangle, noise and DMC channels.
- Decodes writes to $4017. Maintains the frame IRQ flag.
- Sits directly upstream of each channel block.
- Sequencing counts CPU cycles, qualified by `cpu_ce`.

---
 rtl/apu_frame_counter.sv | 79 +++++++
 tb/tb_apu_frame_counter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/apu_frame_counter.sv
// apu_frame_counter: APU frame sequencer and $4017 decode; the frame IRQ flag exists only when APU_FRAME_IRQ_EN is defined
module apu_frame_counter #(
  parameter int Q1 = 7457,
  parameter int Q2 = 14913,
  parameter int Q3 = 22371,
  parameter int Q4 = 29829,
  parameter int Q5 = 37281,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_ce,
  input  logic [4:0] apu_addr,
  input  logic [7:0] data_in,
  input  logic       apu_wr,
  input  logic       status_rd,
  output logic       apu_cycle,
  output logic       qtrframe,
  output logic       halfframe,
  output logic       frame_irq,
  output logic       mode5
);
  localparam logic [CNT_W-1:0] C1 = CNT_W'(Q1);
  localparam logic [CNT_W-1:0] C2 = CNT_W'(Q2);
  localparam logic [CNT_W-1:0] C3 = CNT_W'(Q3);
  localparam logic [CNT_W-1:0] C4M = CNT_W'(Q4 - 1);
  localparam logic [CNT_W-1:0] C4 = CNT_W'(Q4);
  localparam logic [CNT_W-1:0] C4P = CNT_W'(Q4 + 1);
  localparam logic [CNT_W-1:0] C5 = CNT_W'(Q5);
  localparam logic [CNT_W-1:0] C5P = CNT_W'(Q5 + 1);
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0] pend;
  logic phase, inhibit, wr17, fire, match_q, match_h, wrap, set_irq;
  // a write landing on the expiry edge restarts the delay instead of firing
  always_comb begin
    wr17 = cpu_ce & apu_wr & (apu_addr == 5'h17);
    fire = cpu_ce & (pend == 3'd1) & ~wr17;
    match_q = (cnt == C1) | (cnt == C2) | (cnt == C3) | (cnt == (mode5 ? C5 : C4));
    match_h = (cnt == C2) | (cnt == (mode5 ? C5 : C4));
    wrap = cnt == (mode5 ? C5P : C4P);
    set_irq = cpu_ce & ~mode5 & ~inhibit & ((cnt == C4M) | (cnt == C4) | (cnt == C4P));
    cnt_nxt = fire ? '0 : wrap ? CNT_W'(1) : cnt + CNT_W'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      pend <= 3'd0;
      phase <= 1'b0;
      inhibit <= 1'b0;
      mode5 <= 1'b0;
      apu_cycle <= 1'b0;
      qtrframe <= 1'b0;
      halfframe <= 1'b0;
    end else begin
      apu_cycle <= cpu_ce & phase;
      qtrframe <= cpu_ce & (match_q | (fire & mode5));
      halfframe <= cpu_ce & (match_h | (fire & mode5));
      if (cpu_ce) begin
        phase <= ~phase;
        cnt <= cnt_nxt;
        pend <= wr17 ? (phase ? 3'd4 : 3'd3) : (pend != 3'd0) ? pend - 3'd1 : pend;
      end
      if (wr17) begin
        mode5 <= data_in[7];
        inhibit <= data_in[6];
      end
    end
  end
`ifdef APU_FRAME_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) frame_irq <= 1'b0;
    else frame_irq <= set_irq | (frame_irq & ~(status_rd | (wr17 & data_in[6])));
  end
`else
  logic unused_irq;
  assign unused_irq = ^{status_rd, set_irq};
  assign frame_irq = 1'b0;
`endif
endmodule

// File: tb/tb_apu_frame_counter.sv
// tb_apu_frame_counter: randomized scenarios against a frame-position reference model
module tb_apu_frame_counter;
  localparam int Q1 = 97, Q2 = 193, Q3 = 291, Q4 = 389, Q5 = 487;
`ifdef APU_FRAME_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, cpu_ce = 1'b0, apu_wr = 1'b0, status_rd = 1'b0;
  logic [4:0] apu_addr = 5'd0;
  logic [7:0] data_in = 8'd0;
  logic apu_cycle, qtrframe, halfframe, frame_irq, mode5;
  logic [4:0] obs, expv;
  int n_pass = 0, n_chk = 0;
  int total, e, reset_at;
  bit m_mode, m_inh, m_irq;
  apu_frame_counter #(.Q1(Q1), .Q2(Q2), .Q3(Q3), .Q4(Q4), .Q5(Q5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cpu_ce(cpu_ce), .apu_addr(apu_addr), .data_in(data_in),
    .apu_wr(apu_wr), .status_rd(status_rd), .apu_cycle(apu_cycle), .qtrframe(qtrframe),
    .halfframe(halfframe), .frame_irq(frame_irq), .mode5(mode5));
  always #5 clk = ~clk;
  assign obs = {apu_cycle, qtrframe, halfframe, frame_irq, mode5};
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  // frame position of the e-th cpu_ce since the last sequencer reset
  function automatic int posf(input int ev, input bit m);
    int len;
    len = m ? Q5 + 1 : Q4 + 1;
    return ev == 0 ? 0 : ((ev - 1) % len) + 1;
  endfunction
  function automatic logic [4:0] junk_addr();
    logic [4:0] a;
    a = 5'($urandom_range(0, 31));
    return a == 5'h17 ? 5'h16 : a;
  endfunction
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cpu_ce = 1'($urandom_range(0, 1));
    status_rd = 1'b0;
    apu_wr = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_ce = 1'b0;
    total = 0; e = 0; reset_at = -1;
    m_mode = 0; m_inh = 0; m_irq = 0;
    expv = 5'b0;
  endtask
  task automatic step(input bit c, input bit w, input logic [4:0] a, input logic [7:0] d, input bit r);
    bit wr17, set, fire, eq, eh, eac;
    int p;
    @(negedge clk);
    cpu_ce = c; apu_wr = w; apu_addr = a; data_in = d; status_rd = r;
    @(posedge clk);
    #1;
    cpu_ce = 1'b0; apu_wr = 1'b0; status_rd = 1'b0;
    wr17 = c && w && a == 5'h17;
    set = 0; eq = 0; eh = 0; eac = 0;
    if (c) begin
      p = posf(e, m_mode);
      eac = (total % 2) == 1;
      eq = p == Q1 || p == Q2 || p == Q3 || p == (m_mode ? Q5 : Q4);
      eh = p == Q2 || p == (m_mode ? Q5 : Q4);
      set = !m_mode && !m_inh && p >= Q4 - 1 && p <= Q4 + 1;
      fire = reset_at == total && !wr17;
      if (fire) begin
        eq |= m_mode; eh |= m_mode; e = 0; reset_at = -1;
      end else e++;
      if (wr17) begin
        m_mode = d[7]; m_inh = d[6];
        reset_at = total + ((total % 2) == 1 ? 4 : 3);
      end
      total++;
    end
    if (IRQ_EN) m_irq = set || (m_irq && !(r || (wr17 && d[6])));
    expv = {eac, eq, eh, m_irq, m_mode};
  endtask
  task automatic test_reset();
    do_reset();
    n_chk++;
    if (obs !== 5'b0) $display("FAIL reset_outputs got=%b want=00000", obs); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 5'd0, 8'd0, 1'($urandom_range(0, 1)));
      n_chk++;
      if (obs !== expv) $display("FAIL reset_idle clk=%0d got=%b want=%b", i, obs, expv); else n_pass++;
    end
  endtask
  task automatic test_four_step();
    int nq = 0, nh = 0, bad = 0;
    do_reset();
    for (int i = 0; i < Q4 + Q1 + 4; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), junk_addr(), 8'($urandom), 1'b0);
      nq += int'(qtrframe); nh += int'(halfframe);
      if (obs !== expv) begin
        bad++;
        $display("FAIL four_step ce=%0d got=%b want=%b", i, obs, expv);
      end
    end
    n_chk += 3;
    if (bad == 0) n_pass++;
    if (nq !== 5) $display("FAIL four_step_qtr_count got=%0d want=5", nq); else n_pass++;
    if (nh !== 2) $display("FAIL four_step_half_count got=%0d want=2", nh); else n_pass++;
  endtask
  task automatic test_status_rd();
    do_reset();
    while (e < Q4) begin
      step(1'b1, 1'b0, 5'd0, 8'd0, 1'b0);
      if ($urandom_range(0, 7) == 0) step(1'b0, 1'b0, 5'd0, 8'd0, 1'b0);
    end
    n_chk++;
    if (obs !== expv) $display("FAIL status_pre_irq got=%b want=%b", obs, expv); else n_pass++;
    step(1'b1, 1'b0, 5'd0, 8'd0, 1'b1);
    n_chk++;
    if (obs !== expv) $display("FAIL status_rd_coincident_set got=%b want=%b", obs, expv); else n_pass++;
    step(1'b1, 1'b0, 5'd0, 8'd0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 8'd0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 8'd0, 1'b1);
    n_chk++;
    if (obs !== expv) $display("FAIL status_rd_no_ce got=%b want=%b", obs, expv); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      step(1'($urandom_range(0, 1)), 1'b0, 5'd0, 8'd0, 1'($urandom_range(0, 3) == 0));
      n_chk++;
      if (obs !== expv) $display("FAIL status_random clk=%0d got=%b want=%b", i, obs, expv); else n_pass++;
    end
  endtask
  task automatic test_mode5_write(input bit odd);
    int k, first = -1, nq = 0, nh = 0, bad = 0;
    do_reset();
    k = $urandom_range(2, 20);
    if ((k % 2) != int'(odd)) k++;
    for (int i = 0; i < k; i++) step(1'b1, 1'b0, 5'd0, 8'd0, 1'b0);
    step(1'b1, 1'b1, 5'h17, 8'h80, 1'b0);
    for (int i = 0; i < Q5 + 10; i++) begin
      step(1'b1, 1'b0, 5'd0, 8'd0, 1'($urandom_range(0, 15) == 0));
      if (qtrframe && halfframe && first < 0) first = i + 1;
      nq += int'(qtrframe); nh += int'(halfframe);
      if (obs !== expv) begin
        bad++;
        $display("FAIL mode5 phase=%0d ce=%0d got=%b want=%b", odd, i, obs, expv);
      end
    end
    n_chk += 4;
    if (bad == 0) n_pass++;
    if (first !== (odd ? 4 : 3)) $display("FAIL mode5_delay phase=%0d got=%0d want=%0d", odd, first, odd ? 4 : 3); else n_pass++;
    if (nq !== 5) $display("FAIL mode5_qtr_count got=%0d want=5", nq); else n_pass++;
    if (nh !== 3) $display("FAIL mode5_half_count got=%0d want=3", nh); else n_pass++;
  endtask
  task automatic test_inhibit();
    int irq_hi = 0;
    do_reset();
    while (e < Q4 + 3) step(1'b1, 1'b0, 5'd0, 8'd0, 1'b0);
    step(1'b1, 1'b1, 5'h17, 8'h40, 1'b0);
    n_chk++;
    if (obs !== expv) $display("FAIL inhibit_write got=%b want=%b", obs, expv); else n_pass++;
    for (int i = 0; i < Q4 + 8; i++) begin
      step(1'b1, 1'b0, 5'd0, 8'd0, 1'b0);
      irq_hi += int'(frame_irq);
      n_chk++;
      if (obs !== expv) $display("FAIL inhibit_frame ce=%0d got=%b want=%b", i, obs, expv); else n_pass++;
    end
    n_chk++;
    if (irq_hi !== 0) $display("FAIL inhibit_irq_cycles got=%0d want=0", irq_hi); else n_pass++;
  endtask
  task automatic test_back_to_back();
    int k, nb = 0, first = -1, want;
    do_reset();
    k = $urandom_range(2, 10);
    for (int i = 0; i < k; i++) step(1'b1, 1'b0, 5'd0, 8'd0, 1'b0);
    step(1'b1, 1'b1, 5'h17, 8'h80, 1'b0);
    step(1'b1, 1'b0, 5'd0, 8'd0, 1'b0);
    want = ((k + 2) % 2) == 1 ? 4 : 3;
    step(1'b1, 1'b1, 5'h17, 8'h80, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 5'd0, 8'd0, 1'b0);
      if (qtrframe && halfframe) begin
        nb++;
        if (first < 0) first = i + 1;
      end
      n_chk++;
      if (obs !== expv) $display("FAIL b2b ce=%0d got=%b want=%b", i, obs, expv); else n_pass++;
    end
    n_chk += 2;
    if (nb !== 1) $display("FAIL b2b_reset_count got=%0d want=1", nb); else n_pass++;
    if (first !== want) $display("FAIL b2b_delay got=%0d want=%0d", first, want); else n_pass++;
    step(1'b1, 1'b1, 5'h17, 8'h80, 1'b0);
    step(1'b1, 1'b0, 5'd0, 8'd0, 1'b0);
    do_reset();
    n_chk++;
    if (obs !== 5'b0) $display("FAIL rst_mid_delay got=%b want=00000", obs); else n_pass++;
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'($urandom_range(0, 1)), 1'b0, 5'd0, 8'd0, 1'b0);
      nb += int'(qtrframe | halfframe);
      n_chk++;
      if (obs !== expv) $display("FAIL rst_after clk=%0d got=%b want=%b", i, obs, expv); else n_pass++;
    end
    n_chk++;
    if (nb !== 0) $display("FAIL rst_discards_pending got=%0d want=0", nb); else n_pass++;
  endtask
  task automatic test_sparse_ce();
    int nces = Q4 + Q1 + 4, nq = 0, nh = 0, nac = 0, wide = 0, bad = 0;
    bit c, prev = 0;
    do_reset();
    for (int i = 0; i < nces * 3; i++) begin
      c = (i % 3) == 2;
      step(c, c && $urandom_range(0, 1) == 1, junk_addr(), 8'($urandom), $urandom_range(0, 99) == 0);
      nq += int'(qtrframe); nh += int'(halfframe); nac += int'(apu_cycle);
      if (prev && apu_cycle) wide++;
      prev = apu_cycle;
      if (obs !== expv) begin
        bad++;
        $display("FAIL sparse clk=%0d got=%b want=%b", i, obs, expv);
      end
    end
    n_chk += 5;
    if (bad == 0) n_pass++;
    if (nac !== nces / 2) $display("FAIL sparse_apu_cycle_count got=%0d want=%0d", nac, nces / 2); else n_pass++;
    if (wide !== 0) $display("FAIL sparse_apu_cycle_width got=%0d want=0", wide); else n_pass++;
    if (nq !== 5) $display("FAIL sparse_qtr_count got=%0d want=5", nq); else n_pass++;
    if (nh !== 2) $display("FAIL sparse_half_count got=%0d want=2", nh); else n_pass++;
  endtask
  initial begin
    test_reset();
    test_four_step();
    test_status_rd();
    test_mode5_write(1'b0);
    test_mode5_write(1'b1);
    test_inhibit();
    test_back_to_back();
    test_sparse_ce();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
